// File: rtl/phy_rx_deser.sv
// +--------------------------------------------------------------------------+
// | phy_rx_deser : COM-aligned serial-to-byte deserializer with 4-lane demux |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module phy_rx_deser #(
  parameter logic [7:0] COM      = 8'hBC,
  parameter logic [7:0] IDLE     = 8'h7C,
  parameter int         COM_LOCK = 4
) (
  input  logic       clk32f,
  input  logic       reset,
  input  logic       in,
  output logic       active,
  output logic [7:0] out_byte,
  output logic       out_valid,
  output logic [7:0] out0,
  output logic [7:0] out1,
  output logic [7:0] out2,
  output logic [7:0] out3,
  output logic [3:0] valid_out,
  output logic       frame_valid,
  output logic       idle_det
);

  localparam logic [1:0] c_hunt    = 2'd0;
  localparam logic [1:0] c_locking = 2'd1;
  localparam logic [1:0] c_active  = 2'd2;
  localparam logic [3:0] c_lock    = 4'(COM_LOCK);

  logic [1:0] r_state;
  logic [7:0] r_sr;
  logic [2:0] r_bit_cnt;
  logic [3:0] r_com_cnt;
  logic [1:0] r_lane_ptr;
  logic [7:0] r_lane [4];
  logic       r_active;
  logic [7:0] r_out_byte;
  logic       r_out_valid;
  logic [3:0] r_valid_out;
  logic       r_frame_valid;
  logic       r_idle_det;

  logic [7:0] w_nb;
  logic       w_byte_done;
  logic       w_is_com;
  logic       w_is_idle;
  logic [3:0] w_com_inc;

  // The byte under test includes the bit being sampled on this very edge.
  assign w_nb        = {r_sr[6:0], in};
  assign w_byte_done = (r_bit_cnt == 3'd7);
  assign w_is_com    = (w_nb == COM);
  assign w_is_idle   = (w_nb == IDLE);
  assign w_com_inc   = (r_com_cnt == 4'hF) ? 4'hF : r_com_cnt + 4'd1;

  always_ff @(posedge clk32f or posedge reset) begin
    if (reset) begin
      r_state       <= c_hunt;
      r_sr          <= '0;
      r_bit_cnt     <= '0;
      r_com_cnt     <= '0;
      r_lane_ptr    <= '0;
      r_lane        <= '{default: '0};
      r_active      <= 1'b0;
      r_out_byte    <= '0;
      r_out_valid   <= 1'b0;
      r_valid_out   <= '0;
      r_frame_valid <= 1'b0;
      r_idle_det    <= 1'b0;
    end else begin
      r_sr          <= w_nb;
      r_bit_cnt     <= r_bit_cnt + 3'd1;
      r_out_valid   <= 1'b0;
      r_frame_valid <= 1'b0;
      r_idle_det    <= 1'b0;

      case (r_state)
        c_hunt: begin
          if (w_is_com) begin
            r_bit_cnt <= 3'd0;
            r_com_cnt <= 4'd1;
            if (c_lock <= 4'd1) begin
              r_state  <= c_active;
              r_active <= 1'b1;
            end else begin
              r_state <= c_locking;
            end
          end
        end

        c_locking: begin
          if (w_byte_done) begin
            if (w_is_com) begin
              r_com_cnt <= w_com_inc;
              if (w_com_inc >= c_lock) begin
                r_state  <= c_active;
                r_active <= 1'b1;
              end
            end else begin
              r_com_cnt <= 4'd0;
              r_state   <= c_hunt;
            end
          end
        end

        c_active: begin
          if (w_byte_done) begin
            if (w_is_com) begin
              r_lane_ptr  <= 2'd0;
              r_valid_out <= 4'd0;
            end else if (w_is_idle) begin
              r_idle_det <= 1'b1;
            end else begin
              r_out_byte          <= w_nb;
              r_out_valid         <= 1'b1;
              r_lane[r_lane_ptr]  <= w_nb;
              r_lane_ptr          <= r_lane_ptr + 2'd1;
              // Lane 0 opens a new frame, so stale lanes 1..3 are no longer valid.
              if (r_lane_ptr == 2'd0) begin
                r_valid_out <= 4'b0001;
              end else begin
                r_valid_out[r_lane_ptr] <= 1'b1;
              end
              if (r_lane_ptr == 2'd3) begin
                r_frame_valid <= 1'b1;
              end
            end
          end
        end

        default: r_state <= c_hunt;
      endcase
    end
  end

  assign active      = r_active;
  assign out_byte    = r_out_byte;
  assign out_valid   = r_out_valid;
  assign out0        = r_lane[0];
  assign out1        = r_lane[1];
  assign out2        = r_lane[2];
  assign out3        = r_lane[3];
  assign valid_out   = r_valid_out;
  assign frame_valid = r_frame_valid;
  assign idle_det    = r_idle_det;

endmodule

`default_nettype wire

// File: tb/tb_phy_rx_deser.sv
// +--------------------------------------------------------------------------+
// | tb_phy_rx_deser : bench for phy_rx_deser (COM_LOCK = 4 and COM_LOCK = 1) |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_phy_rx_deser;

  localparam int         MAXN = 600;
  localparam logic [7:0] COM  = 8'hBC;
  localparam logic [7:0] IDLE = 8'h7C;

  typedef struct packed {
    logic       act;
    logic [7:0] ob;
    logic       ov;
    logic [7:0] l3;
    logic [7:0] l2;
    logic [7:0] l1;
    logic [7:0] l0;
    logic [3:0] vo;
    logic       fv;
    logic       id;
  } obs_t;

  logic clk;
  logic rst;
  logic din;

  logic       act4, ov4, fv4, id4;
  logic [7:0] ob4, o40, o41, o42, o43;
  logic [3:0] vo4;
  logic       act1, ov1, fv1, id1;
  logic [7:0] ob1, o10, o11, o12, o13;
  logic [3:0] vo1;

  obs_t obs4, obs1;
  assign obs4 = {act4, ob4, ov4, o43, o42, o41, o40, vo4, fv4, id4};
  assign obs1 = {act1, ob1, ov1, o13, o12, o11, o10, vo1, fv1, id1};

  phy_rx_deser #(.COM(COM), .IDLE(IDLE), .COM_LOCK(4)) dut (
    .clk32f(clk), .reset(rst), .in(din),
    .active(act4), .out_byte(ob4), .out_valid(ov4),
    .out0(o40), .out1(o41), .out2(o42), .out3(o43),
    .valid_out(vo4), .frame_valid(fv4), .idle_det(id4)
  );

  phy_rx_deser #(.COM(COM), .IDLE(IDLE), .COM_LOCK(1)) dut1 (
    .clk32f(clk), .reset(rst), .in(din),
    .active(act1), .out_byte(ob1), .out_valid(ov1),
    .out0(o10), .out1(o11), .out2(o12), .out3(o13),
    .valid_out(vo1), .frame_valid(fv1), .idle_det(id1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  bit   stim[$];
  obs_t got4 [0:MAXN];
  obs_t got1 [0:MAXN];
  obs_t exp4 [0:MAXN];
  obs_t exp1 [0:MAXN];
  obs_t m_exp[0:MAXN];

  // Byte seen by the receiver at edge k (1-based); the line idles at 0 before the stream.
  function automatic logic [7:0] win(input int k);
    logic [7:0] v = '0;
    for (int j = 0; j < 8; j++) begin
      int idx = k - 8 + j;
      v = {v[6:0], (idx >= 0) ? stim[idx] : 1'b0};
    end
    return v;
  endfunction

  // Reference: locate alignment on the whole stream first, then replay the byte events.
  task automatic build_model(input int lock);
    int         n, k, kk, cnt;
    bit         locked, done;
    int         ev_kind [0:MAXN];
    logic [7:0] ev_val  [0:MAXN];
    logic [7:0] b;
    obs_t       s;
    logic [1:0] ptr;
    n = stim.size();
    for (int e = 0; e <= MAXN; e++) begin ev_kind[e] = 0; ev_val[e] = '0; end
    k = 1; kk = 0; locked = 0;
    while (k <= n && !locked) begin
      if (win(k) == COM) begin
        cnt = 1;
        kk  = k + 8;
        if (cnt >= lock) begin
          ev_kind[k] = 1; locked = 1;
        end else begin
          done = 0;
          while (kk <= n && !done) begin
            if (win(kk) == COM) begin
              cnt = (cnt < 15) ? cnt + 1 : 15;
              if (cnt >= lock) begin ev_kind[kk] = 1; locked = 1; done = 1; end
              kk += 8;
            end else begin
              done = 1;
            end
          end
          k = kk + 1;
        end
      end else begin
        k++;
      end
    end
    if (locked) begin
      for (int e = kk; e <= n; e += 8) begin
        b = win(e);
        ev_val[e]  = b;
        ev_kind[e] = (b == COM) ? 4 : (b == IDLE) ? 3 : 2;
      end
    end
    s = '0; ptr = 2'd0;
    m_exp[0] = s;
    for (int e = 1; e <= n; e++) begin
      s.ov = 0; s.fv = 0; s.id = 0;
      b = ev_val[e];
      case (ev_kind[e])
        1: s.act = 1;
        2: begin
          s.ob = b; s.ov = 1;
          case (ptr)
            2'd0: begin s.l0 = b; s.vo = 4'b0001; end
            2'd1: begin s.l1 = b; s.vo[1] = 1'b1; end
            2'd2: begin s.l2 = b; s.vo[2] = 1'b1; end
            default: begin s.l3 = b; s.vo[3] = 1'b1; s.fv = 1; end
          endcase
          ptr = ptr + 2'd1;
        end
        3: s.id = 1;
        4: begin ptr = 2'd0; s.vo = 4'd0; end
        default: ;
      endcase
      m_exp[e] = s;
    end
  endtask

  task automatic build_both();
    build_model(4); exp4 = m_exp;
    build_model(1); exp1 = m_exp;
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) stim.push_back(b[i]);
  endtask

  task automatic push_rand_bits(input int n);
    for (int i = 0; i < n; i++) stim.push_back(1'($urandom));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; din = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives the stream and records what both DUTs show just after each edge.
  task automatic run_stim();
    got4[0] = obs4; got1[0] = obs1;
    for (int k = 1; k <= stim.size(); k++) begin
      @(negedge clk) din = stim[k-1];
      @(posedge clk);
      #1;
      got4[k] = obs4; got1[k] = obs1;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin @(negedge clk) din = 1'($urandom); end
    total++;
    if (obs4 !== '0 || obs1 !== '0) begin
      bad++; $display("FAIL reset_held got=%h/%h exp=0", obs4, obs1);
    end
    rst = 1'b0; din = 1'b0;
    @(negedge clk);
    total++;
    if (obs4 !== '0 || obs1 !== '0) begin
      bad++; $display("FAIL reset_released got=%h/%h exp=0", obs4, obs1);
    end
  endtask

  task automatic test_aligned();
    int npulse = 0;
    do_reset();
    stim.delete();
    repeat (4) push_byte(COM);
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
    run_stim(); build_both();
    for (int k = 0; k <= stim.size(); k++) begin
      total += 2;
      if (got4[k] !== exp4[k]) begin bad++; $display("FAIL aligned dut4 edge=%0d got=%h exp=%h", k, got4[k], exp4[k]); end
      if (got1[k] !== exp1[k]) begin bad++; $display("FAIL aligned dut1 edge=%0d got=%h exp=%h", k, got1[k], exp1[k]); end
      if (got4[k].ov) npulse++;
    end
    total++;
    if (got4[31].act !== 1'b0 || got4[32].act !== 1'b1) begin
      bad++; $display("FAIL aligned_active_edge got=%b%b exp=01", got4[31].act, got4[32].act);
    end
    total++;
    if ({got4[64].l0, got4[64].l1, got4[64].l2, got4[64].l3, got4[64].vo, got4[64].fv} !== {32'h11223344, 4'hF, 1'b1}) begin
      bad++; $display("FAIL aligned_frame got=%h exp=11223344 F 1", got4[64]);
    end
    total++;
    if (npulse != 4 || !(got4[40].ov && got4[48].ov && got4[56].ov && got4[64].ov)) begin
      bad++; $display("FAIL aligned_out_valid got=%0d pulses exp=4 at 40,48,56,64", npulse);
    end
  endtask

  task automatic test_misaligned();
    do_reset();
    stim.delete();
    push_rand_bits(3);
    repeat (4) push_byte(COM);
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
    run_stim(); build_both();
    for (int k = 0; k <= stim.size(); k++) begin
      total += 2;
      if (got4[k] !== exp4[k]) begin bad++; $display("FAIL misaligned dut4 edge=%0d got=%h exp=%h", k, got4[k], exp4[k]); end
      if (got1[k] !== exp1[k]) begin bad++; $display("FAIL misaligned dut1 edge=%0d got=%h exp=%h", k, got1[k], exp1[k]); end
    end
    total++;
    if (got4[34].act !== 1'b0 || got4[35].act !== 1'b1 || got4[67].fv !== 1'b1 ||
        {got4[67].l0, got4[67].l1, got4[67].l2, got4[67].l3} !== 32'h11223344) begin
      bad++; $display("FAIL misaligned_shift got35=%h got67=%h", got4[35], got4[67]);
    end
  endtask

  task automatic test_broken_lock();
    do_reset();
    stim.delete();
    push_byte(COM); push_byte(COM); push_byte(8'h55);
    repeat (4) push_byte(COM);
    push_byte(8'hA5);
    run_stim(); build_both();
    for (int k = 0; k <= stim.size(); k++) begin
      total += 2;
      if (got4[k] !== exp4[k]) begin bad++; $display("FAIL broken dut4 edge=%0d got=%h exp=%h", k, got4[k], exp4[k]); end
      if (got1[k] !== exp1[k]) begin bad++; $display("FAIL broken dut1 edge=%0d got=%h exp=%h", k, got1[k], exp1[k]); end
    end
    total++;
    if (got4[55].act !== 1'b0 || got4[56].act !== 1'b1) begin
      bad++; $display("FAIL broken_active_edge got=%b%b exp=01", got4[55].act, got4[56].act);
    end
    total++;
    if (got4[64].l0 !== 8'hA5 || got4[64].vo !== 4'h1) begin
      bad++; $display("FAIL broken_out0 got=%h/%h exp=a5/1", got4[64].l0, got4[64].vo);
    end
  endtask

  task automatic test_idle_reframe();
    int nidle = 0, nfv = 0;
    do_reset();
    stim.delete();
    repeat (4) push_byte(COM);
    push_byte(8'h01); push_byte(IDLE); push_byte(8'h02); push_byte(COM); push_byte(8'h03);
    run_stim(); build_both();
    for (int k = 0; k <= stim.size(); k++) begin
      total += 2;
      if (got4[k] !== exp4[k]) begin bad++; $display("FAIL idle dut4 edge=%0d got=%h exp=%h", k, got4[k], exp4[k]); end
      if (got1[k] !== exp1[k]) begin bad++; $display("FAIL idle dut1 edge=%0d got=%h exp=%h", k, got1[k], exp1[k]); end
      if (got4[k].id) nidle++;
      if (got4[k].fv) nfv++;
    end
    total++;
    if (nidle != 1 || got4[48].id !== 1'b1) begin
      bad++; $display("FAIL idle_pulse got=%0d exp=1 at 48", nidle);
    end
    total++;
    if (got4[64].vo !== 4'h0) begin
      bad++; $display("FAIL idle_com_clears got=%h exp=0", got4[64].vo);
    end
    total++;
    if (got4[72].l0 !== 8'h03 || got4[72].vo !== 4'h1 || nfv != 0) begin
      bad++; $display("FAIL idle_reframe got=%h/%h fv=%0d exp=03/1/0", got4[72].l0, got4[72].vo, nfv);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    stim.delete();
    repeat (4) push_byte(COM);
    push_byte(8'h11);
    stim.push_back(1'b0); stim.push_back(1'b0); stim.push_back(1'b1); stim.push_back(1'b0);
    run_stim();
    total++;
    if (got4[44].act !== 1'b1 || got4[44].l0 !== 8'h11) begin
      bad++; $display("FAIL resetmid_pre got=%h exp act=1 l0=11", got4[44]);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (obs4 !== '0 || obs1 !== '0) begin
      bad++; $display("FAIL resetmid_async got=%h/%h exp=0", obs4, obs1);
    end
    @(negedge clk) rst = 1'b0; din = 1'b0;
    stim.delete();
    repeat (4) push_byte(COM);
    run_stim(); build_both();
    for (int k = 0; k <= stim.size(); k++) begin
      total += 2;
      if (got4[k] !== exp4[k]) begin bad++; $display("FAIL relock dut4 edge=%0d got=%h exp=%h", k, got4[k], exp4[k]); end
      if (got1[k] !== exp1[k]) begin bad++; $display("FAIL relock dut1 edge=%0d got=%h exp=%h", k, got1[k], exp1[k]); end
    end
    total++;
    if (got4[31].act !== 1'b0 || got4[32].act !== 1'b1 || got4[32].ov !== 1'b0) begin
      bad++; $display("FAIL relock_active got=%h exp act rises at 32", got4[32]);
    end
  endtask

  task automatic test_com_lock1();
    do_reset();
    stim.delete();
    push_byte(COM); push_byte(8'h9A);
    run_stim(); build_both();
    for (int k = 0; k <= stim.size(); k++) begin
      total += 2;
      if (got4[k] !== exp4[k]) begin bad++; $display("FAIL lock1 dut4 edge=%0d got=%h exp=%h", k, got4[k], exp4[k]); end
      if (got1[k] !== exp1[k]) begin bad++; $display("FAIL lock1 dut1 edge=%0d got=%h exp=%h", k, got1[k], exp1[k]); end
    end
    total++;
    if (got1[7].act !== 1'b0 || got1[8].act !== 1'b1) begin
      bad++; $display("FAIL lock1_active got=%b%b exp=01", got1[7].act, got1[8].act);
    end
    total++;
    if (got1[16].l0 !== 8'h9A || got1[16].ov !== 1'b1 || got4[16].act !== 1'b0) begin
      bad++; $display("FAIL lock1_data got=%h/%b act4=%b exp=9a/1/0", got1[16].l0, got1[16].ov, got4[16].act);
    end
  endtask

  task automatic test_random();
    int r;
    for (int it = 0; it < 4; it++) begin
      do_reset();
      stim.delete();
      push_rand_bits($urandom_range(0, 7));
      repeat ($urandom_range(20, 40)) begin
        r = $urandom_range(0, 9);
        if (r < 3)       push_byte(COM);
        else if (r == 3) push_byte(IDLE);
        else             push_byte(8'($urandom));
      end
      run_stim(); build_both();
      for (int k = 0; k <= stim.size(); k++) begin
        total += 2;
        if (got4[k] !== exp4[k]) begin bad++; $display("FAIL random%0d dut4 edge=%0d got=%h exp=%h", it, k, got4[k], exp4[k]); end
        if (got1[k] !== exp1[k]) begin bad++; $display("FAIL random%0d dut1 edge=%0d got=%h exp=%h", it, k, got1[k], exp1[k]); end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    din = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    test_aligned();
    test_misaligned();
    test_broken_lock();
    test_idle_reframe();
    test_reset_mid();
    test_com_lock1();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
